// File: rtl/rv32i_memaccess_pkg.sv
// Shared definitions for the rv32i memory-access stage: opcode/exception bit
// positions, funct3 encodings and the bus FSM state type.
package rv32i_memaccess_pkg;

  localparam int OPCODE_WIDTH    = 11;
  localparam int EXCEPTION_WIDTH = 7;

  // one-hot opcode bundle bit positions
  localparam int OP_RTYPE  = 0;
  localparam int OP_ITYPE  = 1;
  localparam int OP_LOAD   = 2;
  localparam int OP_STORE  = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_JAL    = 5;
  localparam int OP_JALR   = 6;
  localparam int OP_LUI    = 7;
  localparam int OP_AUIPC  = 8;
  localparam int OP_SYSTEM = 9;
  localparam int OP_FENCE  = 10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // exception flag bit positions; the upper three are raised by this stage
  localparam int EXC_ILLEGAL          = 0;
  localparam int EXC_ECALL            = 1;
  localparam int EXC_EBREAK           = 2;
  localparam int EXC_MRET             = 3;
  localparam int EXC_LOAD_MISALIGNED  = 4;
  localparam int EXC_STORE_MISALIGNED = 5;
  localparam int EXC_BUS_ERROR        = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } mem_state_t;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv32i_memaccess_lanes.sv
// Byte-lane steering for stores, alignment check, and load byte/half
// extraction with sign or zero extension.
module rv32i_memaccess_lanes
  import rv32i_memaccess_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] store_data,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] bus_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    sel   = 4'b0000;
    wdata = store_data;
    case (size)
      2'b00: begin
        sel   = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        sel   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: sel = 4'b1111;
    endcase
  end

  assign misaligned = is_misaligned(size, addr_lo);

  // move the addressed byte/half down to bit 0 before extending
  assign shifted = bus_data >> {ld_offset, 3'b000};

  always_comb begin
    load_data = bus_data;
    case (ld_funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = bus_data;
    endcase
  end

endmodule

// File: rtl/rv32i_memaccess.sv
// rv32i memory-access stage: runs a pipelined Wishbone transaction for
// loads/stores, stalls execute while it is outstanding, forwards writeback info.
module rv32i_memaccess
  import rv32i_memaccess_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [31:0]                i_y,
  input  logic [31:0]                i_rs2,
  input  logic [2:0]                 i_funct3,
  input  logic [OPCODE_WIDTH-1:0]    i_opcode,
  input  logic [EXCEPTION_WIDTH-1:0] i_exception,
  input  logic [4:0]                 i_rd_addr,
  input  logic                       i_wr_rd,
  input  logic                       i_ce,
  input  logic                       i_stall,
  input  logic                       i_flush,
  output logic                       o_stall_from_mem,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic                       o_wb_we,
  output logic [31:0]                o_wb_addr,
  output logic [31:0]                o_wb_data,
  output logic [3:0]                 o_wb_sel,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_stall,
  input  logic [31:0]                i_wb_data,
  output logic [4:0]                 o_rd_addr,
  output logic [31:0]                o_rd,
  output logic                       o_wr_rd,
  output logic [EXCEPTION_WIDTH-1:0] o_exception,
  output logic                       o_ce,
  output logic                       o_flush
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [EXCEPTION_WIDTH-1:0] BUS_ERR_MASK = EXCEPTION_WIDTH'(1 << EXC_BUS_ERROR);

  mem_state_t state, state_next;

  logic [CNT_W-1:0] tmo_cnt;
  logic             pend_load;
  logic             pend_wr_rd;
  logic             pend_flush;
  logic [2:0]       pend_funct3;
  logic [1:0]       pend_offset;
  logic             skip;

  logic is_load, is_store, is_mem;
  logic accept, start_bus, misalign_hit;
  logic done_now, bus_err;
  logic misaligned;
  logic [3:0]  lane_sel;
  logic [31:0] lane_data;
  logic [31:0] load_data;
  logic [EXCEPTION_WIDTH-1:0] misalign_exc;
  logic unused_opcode;

  assign unused_opcode = ^i_opcode;

  assign is_load  = i_opcode[OP_LOAD];
  assign is_store = i_opcode[OP_STORE];
  // an instruction already carrying an exception never touches the bus
  assign is_mem   = (is_load || is_store) && (i_exception == '0);

  // skip: execute is still presenting the instruction that just finished
  assign accept       = i_ce && !i_stall && !i_flush && (state == ST_IDLE) && !skip;
  assign start_bus    = accept && is_mem && !misaligned;
  assign misalign_hit = accept && is_mem && misaligned;

  always_comb begin
    misalign_exc = '0;
    misalign_exc[EXC_LOAD_MISALIGNED]  = is_load;
    misalign_exc[EXC_STORE_MISALIGNED] = is_store && !is_load;
  end

  rv32i_memaccess_lanes u_lanes (
    .addr_lo    (i_y[1:0]),
    .size       (i_funct3[1:0]),
    .store_data (i_rs2),
    .sel        (lane_sel),
    .wdata      (lane_data),
    .misaligned (misaligned),
    .ld_funct3  (pend_funct3),
    .ld_offset  (pend_offset),
    .bus_data   (i_wb_data),
    .load_data  (load_data)
  );

  always_comb begin
    state_next = state;
    done_now   = 1'b0;
    bus_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_bus) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (!i_wb_stall) begin
          if (i_wb_ack) begin
            state_next = ST_DONE;
            done_now   = 1'b1;
          end else begin
            state_next = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (i_wb_ack) begin
          state_next = ST_DONE;
          done_now   = 1'b1;
        end else if (tmo_cnt <= CNT_W'(1)) begin
          state_next = ST_DONE;
          done_now   = 1'b1;
          bus_err    = 1'b1;
        end
      end
      ST_DONE: begin
        if (!i_stall || i_flush) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    o_stall_from_mem = start_bus || (state != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      pend_load   <= 1'b0;
      pend_wr_rd  <= 1'b0;
      pend_flush  <= 1'b0;
      pend_funct3 <= '0;
      pend_offset <= '0;
      skip        <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_wb_sel    <= '0;
      o_rd_addr   <= '0;
      o_rd        <= '0;
      o_wr_rd     <= 1'b0;
      o_exception <= '0;
      o_ce        <= 1'b0;
      o_flush     <= 1'b0;
    end else begin
      state   <= state_next;
      o_flush <= i_flush;
      case (state)
        ST_IDLE: begin
          if (i_flush) begin
            o_ce    <= 1'b0;
            o_wr_rd <= 1'b0;
            skip    <= 1'b0;
          end else if (accept) begin
            o_rd_addr <= i_rd_addr;
            o_rd      <= i_y;
            if (start_bus) begin
              o_ce        <= 1'b0;
              o_wr_rd     <= 1'b0;
              o_exception <= i_exception;
              o_wb_cyc    <= 1'b1;
              o_wb_stb    <= 1'b1;
              o_wb_we     <= is_store;
              o_wb_addr   <= {i_y[31:2], 2'b00};
              o_wb_data   <= lane_data;
              o_wb_sel    <= lane_sel;
              pend_load   <= is_load;
              pend_wr_rd  <= i_wr_rd && is_load;
              pend_funct3 <= i_funct3;
              pend_offset <= i_y[1:0];
              pend_flush  <= 1'b0;
            end else if (misalign_hit) begin
              o_ce        <= 1'b1;
              o_wr_rd     <= 1'b0;
              o_exception <= i_exception | misalign_exc;
            end else begin
              o_ce        <= 1'b1;
              o_wr_rd     <= i_wr_rd;
              o_exception <= i_exception;
            end
          end else if (!i_stall) begin
            o_ce <= 1'b0;
            skip <= 1'b0;
          end
        end
        ST_REQ: begin
          if (i_flush) pend_flush <= 1'b1;
          if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            tmo_cnt  <= CNT_LOAD;
          end
        end
        ST_WAIT_ACK: begin
          if (i_flush) pend_flush <= 1'b1;
          tmo_cnt <= tmo_cnt - 1'b1;
        end
        ST_DONE: begin
          if (i_flush || !i_stall) begin
            o_ce       <= 1'b0;
            pend_flush <= 1'b0;
            skip       <= !i_flush;
          end
        end
        default: ;
      endcase
      if (done_now) begin
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        tmo_cnt  <= '0;
        if (pend_load && !bus_err) o_rd <= load_data;
        o_wr_rd <= pend_wr_rd && !bus_err;
        if (bus_err) o_exception <= o_exception | BUS_ERR_MASK;
        o_ce <= !(pend_flush || i_flush);
      end
    end
  end

endmodule

// File: doc/rv32i_memaccess.md
Name: rv32i_memaccess

Overview:
Memory-access stage of the rv32i core, directly downstream of the execute/ALU stage. Consumes the ALU result (effective address), rs2 store data, funct3 and opcode. For loads/stores it runs a pipelined Wishbone-style transaction with byte lanes, stalling upstream until the bus responds. Forwards rd/writeback info and sign/zero-extended load data to writeback.

Parameters:
TIMEOUT_CYCLES, 255, cycles in WAIT_ACK with no i_wb_ack before a bus error is raised (counter width = clog2(TIMEOUT_CYCLES+1))

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_y  in  32  ALU result; effective address for load/store, else rd value
i_rs2  in  32  store data
i_funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
i_opcode  in  `OPCODE_WIDTH  one-hot opcode bundle; load/store bits used here
i_exception  in  `EXCEPTION_WIDTH  upstream exception flags
i_rd_addr  in  5  destination register
i_wr_rd  in  1  rd write enable from execute
i_ce  in  1  valid from execute
i_stall  in  1  stall from downstream
i_flush  in  1  flush (kills this stage's input and outputs)
o_stall_from_mem  out  1  stalls execute while a bus transaction is outstanding
o_wb_cyc  out  1  bus cycle
o_wb_stb  out  1  request strobe
o_wb_we  out  1  1 = store
o_wb_addr  out  32  word address ({i_y[31:2],2'b00})
o_wb_data  out  32  lane-steered store data
o_wb_sel  out  4  byte enables
i_wb_ack  in  1  response
i_wb_stall  in  1  slave not accepting strobe
i_wb_data  in  32  load data
o_rd_addr  out  5  forwarded
o_rd  out  32  i_y for non-loads, extended load data for loads
o_wr_rd  out  1  forwarded write enable (0 on misalign/bus error)
o_exception  out  `EXCEPTION_WIDTH  upstream flags OR'd with misaligned-load/store and bus-error bits
o_ce  out  1  valid to writeback
o_flush  out  1  registered i_flush

Behaviour:
- Reset (async, i_rst_n=0): FSM=IDLE; o_wb_cyc/stb/we=0, o_wb_sel=0, o_wb_addr/data=0; o_ce=0, o_wr_rd=0, o_stall_from_mem=0, o_exception=0, o_rd=0, o_rd_addr=0, o_flush=0; timeout counter=0. Reset mid-transaction abandons it; no ack is awaited afterwards.
- Accept: i_ce && !i_stall && !i_flush && state==IDLE. Non-memory op: outputs registered next edge, o_ce=1, latency 1.
- Byte lanes: SB sel=4'b0001<<addr[1:0], data={4{rs2[7:0]}}; SH sel=addr[1]?1100:0011, data={2{rs2[15:0]}}; SW sel=1111, data=rs2. Loads use same sel.
- Misalignment (half with addr[0]=1, word with addr[1:0]!=0): no bus request; set misaligned bit in o_exception, o_wr_rd=0, o_ce=1 at latency 1.
- FSM: IDLE -> REQ on accepted aligned load/store (cyc=stb=1 from next edge). REQ: hold stb/addr/data/sel/we until a cycle with !i_wb_stall, then -> WAIT_ACK (stb=0, cyc=1). Ack in REQ with !i_wb_stall completes directly. WAIT_ACK: on i_wb_ack capture data -> DONE; counter++ each cycle, at TIMEOUT_CYCLES -> DONE with bus-error bit, o_wr_rd=0. DONE: cyc=0, o_ce=1 one cycle (held while i_stall), then IDLE.
- o_stall_from_mem=1 combinationally from acceptance of a load/store through the DONE cycle, so execute holds its outputs.
- Load extend: LB/LH sign-extend selected byte/half; LBU/LHU zero-extend; LW passthrough.
- i_stall: all registered outputs hold; bus FSM still progresses (ack never dropped); a DONE result holds until i_stall=0.
- i_flush in IDLE: o_ce=0 next cycle. i_flush while transaction in flight: bus cycle completes, result discarded (o_ce=0).
- o_ce deasserts for one cycle after any single-cycle result if no new accept.

Decomposition:
- rv32i_header: OPCODE_WIDTH, EXCEPTION_WIDTH, opcode one-hot indices, funct3 load/store encodings, new exception bit indices (LOAD_MISALIGNED, STORE_MISALIGNED, BUS_ERROR), FSM state enum.
- Sub-module rv32i_memaccess_lanes: combinational sel/store-data steering, misalign detect, load extraction/extension.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, ack 2 cycles after stb -> sel=1111, data=0xDEADBEEF, we=1, stall high 4 cycles, o_wr_rd=0.
- SB addr 0x103, rs2 0x000000A5 -> sel=1000, data=0xA5A5A5A5.
- LB addr 0x202, wb_data 0x0080_0000 -> o_rd=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x202 -> 0x00000080.
- LW addr 0x101 -> no cyc, load-misaligned bit set, o_ce=1 next cycle, o_wr_rd=0.
- i_wb_stall high 3 cycles in REQ -> stb/addr held stable 4 cycles; no ack for 255 cycles -> bus-error bit, FSM back to IDLE.
- Reset asserted during WAIT_ACK -> cyc=0 immediately, all outputs reset values; ADD (i_y=7) after reset -> o_rd=7, o_ce=1 at latency 1.
